// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: run controller for the serial pattern detector.
// Takes a runtime pattern configuration through a valid/ready handshake,
// arms, runs on start, and scans a serial bit stream for the pattern.
// It can stop after a target number of matches, or run until aborted.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   cfg_valid/ready  configuration handshake (ready in IDLE/ARMED)
//   cfg_pattern      pattern, bit [cfg_len-1] received first
//   cfg_len          pattern length, legal 1..MAX_LEN
//   cfg_overlap      1 = overlapping matches
//   cfg_target       match count that ends the run, 0 = unbounded
//   cfg_err          pulse: illegal cfg_len offered
//   start, abort     run control
//   in_valid, in     serial stream bit
//   match            pulse per detected match
//   match_count      matches in the current/last run
//   busy             high while running
//   done             pulse when the target is reached
module seq_match_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched configuration and scan state
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  // Next values of the registered outputs
  logic               cfg_ready_d, cfg_err_d, match_d, busy_d, done_d;
  logic [CNT_W-1:0]   cnt_d;

  // Shared decode
  logic               cfg_legal, cfg_xfer, cfg_load;
  logic               run_clr, run_step;
  logic [MAX_LEN-1:0] hist_nxt, mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit, tgt_hit;

  // Match evaluation on the history that would result from this bit
  always_comb begin
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_MAX);
    cfg_xfer  = cfg_valid && cfg_ready;
    // abort is only meaningful in ARMED; it blocks a config load there
    cfg_load  = cfg_xfer && cfg_legal && !((state_q == S_ARMED) && abort);
    run_clr   = (state_q == S_ARMED) && start && !abort;
    run_step  = (state_q == S_RUN) && in_valid && !abort;

    hist_nxt  = {hist_q[MAX_LEN-2:0], in};
    fill_inc  = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    // fill_inc saturates at MAX_LEN >= len, so this equals (fill+1) >= len
    hit       = (fill_inc >= len_q) && (((hist_nxt ^ pat_q) & mask) == '0);
    cnt_inc   = (match_count == '1) ? match_count : match_count + 1'b1;
    tgt_hit   = (tgt_q != '0) && (cnt_inc == tgt_q);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks start and match
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cfg_xfer && cfg_legal) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)                             state_d = S_IDLE;
        else if (in_valid && hit && tgt_hit)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    tgt_d       = tgt_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    cnt_d       = match_count;
    cfg_err_d   = cfg_xfer && !cfg_legal;
    match_d     = run_step && hit;
    busy_d      = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    cfg_ready_d = (state_d == S_IDLE) || (state_d == S_ARMED);

    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
    end

    if (run_clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (run_step) begin
      hist_d = hist_nxt;
      // Non-overlapping mode discards the bits consumed by a match
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
      if (hit) cnt_d = cnt_inc;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      tgt_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      match_count <= '0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
      match       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      tgt_q       <= tgt_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      match_count <= cnt_d;
      cfg_ready   <= cfg_ready_d;
      cfg_err     <= cfg_err_d;
      match       <= match_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: one vector per clock, outputs
// compared 1 time unit after the rising edge that consumed the vector.
module tb_seq_match_ctrl;

  logic       clk;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       cfg_err;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in_bit;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_match_ctrl #(.MAX_LEN(8), .CNT_W(8), .LEN_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (in_bit),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic [7:0] tgt;
    logic       st;
    logic       ab;
    logic       iv;
    logic       bi;
    logic       e_rdy;
    logic       e_err;
    logic       e_m;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vq[$];

  function automatic void p(input int cv, input int pat, input int len, input int ov,
                            input int tgt, input int st, input int ab, input int iv,
                            input int bi, input int rdy, input int err, input int m,
                            input int cnt, input int bsy, input int dn);
    vec_t v;
    v.cv = 1'(cv);   v.pat = 8'(pat); v.len = 4'(len); v.ov = 1'(ov);
    v.tgt = 8'(tgt); v.st = 1'(st);   v.ab = 1'(ab);   v.iv = 1'(iv);
    v.bi = 1'(bi);   v.e_rdy = 1'(rdy); v.e_err = 1'(err); v.e_m = 1'(m);
    v.e_cnt = 8'(cnt); v.e_busy = 1'(bsy); v.e_done = 1'(dn);
    vq.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    cfg_valid   = v.cv;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ov;
    cfg_target  = v.tgt;
    start       = v.st;
    abort       = v.ab;
    in_valid    = v.iv;
    in_bit      = v.bi;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int rdy, input int err, input int m,
                         input int cnt, input int bsy, input int dn);
    chk({tag, "_cfg_ready"},   32'(cfg_ready),   32'(rdy));
    chk({tag, "_cfg_err"},     32'(cfg_err),     32'(err));
    chk({tag, "_match"},       32'(match),       32'(m));
    chk({tag, "_match_count"}, 32'(match_count), 32'(cnt));
    chk({tag, "_busy"},        32'(busy),        32'(bsy));
    chk({tag, "_done"},        32'(done),        32'(dn));
  endtask

  // Stream bit in RUN: p(cfg..., start, abort, in_valid, in, expected...)
  task automatic bit_run(input int iv, input int b, input int m, input int cnt);
    p(0, 0, 0, 0, 0, 0, 0, iv, b, 0, 0, m, cnt, 1, 0);
  endtask

  initial begin
    vec_t idle_v;
    idle_v = '{default: '0};
    drive(idle_v);
    reset_n = 1'b0;
    #12;
    chk_all("reset", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Overlap: 0110, len 4, stream 0,1,1,0,1,1,0
    p(1, 6, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    bit_run(1, 0, 0, 0); bit_run(1, 1, 0, 0); bit_run(1, 1, 0, 0); bit_run(1, 0, 1, 1);
    bit_run(1, 1, 0, 1); bit_run(1, 1, 0, 1); bit_run(1, 0, 1, 2);
    p(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2, 0, 0);

    // Non-overlap, same stream: only one match
    p(1, 6, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    bit_run(1, 0, 0, 0); bit_run(1, 1, 0, 0); bit_run(1, 1, 0, 0); bit_run(1, 0, 1, 1);
    bit_run(1, 1, 0, 1); bit_run(1, 1, 0, 1); bit_run(1, 0, 0, 1);
    p(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);

    // Target 3, pattern '1' len 1, stream 1,0,1,1 with in_valid gaps
    p(1, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    bit_run(1, 1, 1, 1); bit_run(0, 1, 0, 1); bit_run(1, 0, 0, 1); bit_run(0, 0, 0, 1);
    bit_run(1, 1, 1, 2);
    p(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 3, 0, 1);
    p(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0);

    // Illegal lengths 0 and MAX_LEN+1: error pulse, stay IDLE, start ignored
    p(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    p(1, 5, 9, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0);

    // Abort on the bit that would complete 0110
    p(1, 6, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    bit_run(1, 0, 0, 0); bit_run(1, 1, 0, 0); bit_run(1, 1, 0, 0);
    p(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Full-width pattern 10110011, target 1
    p(1, 'hB3, 8, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    bit_run(1, 1, 0, 0); bit_run(1, 0, 0, 0); bit_run(1, 1, 0, 0); bit_run(1, 1, 0, 0);
    bit_run(1, 0, 0, 0); bit_run(1, 0, 0, 0); bit_run(1, 1, 0, 0);
    p(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1);
    p(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vq[i].e_rdy, vq[i].e_err, vq[i].e_m,
              vq[i].e_cnt, vq[i].e_busy, vq[i].e_done);
    end

    // Async reset mid-run: pattern '1', overlap, three matching bits (fill 3)
    vq.delete();
    p(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    p(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
    end
    drive(idle_v);
    chk_all("pre_rst", 0, 0, 1, 3, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("mid_rst", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Run controller for the serial pattern detector path: accepts a programmable pattern configuration, arms on `start`, and scans a serial bit stream for the pattern. It runs until a target match count is reached or it is aborted, with overlapping or non-overlapping matching. It sits between the configuration/control agent and the serial data source. It replaces fixed-pattern detection with a runtime-configured, counted, and handshaked scan.

## Interface
- `MAX_LEN`, 8, maximum pattern length in bits (2..16).
- `CNT_W`, 8, width of match counter and target.
- `LEN_W`, 4, width of `cfg_len`; must hold `MAX_LEN`.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted (IDLE or ARMED).
- `cfg_pattern`  in  MAX_LEN  pattern; bit `[cfg_len-1]` is first received, bit `[0]` last.
- `cfg_len`  in  LEN_W  pattern length, legal 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `cfg_target`  in  CNT_W  matches to finish run; 0 = unbounded.
- `cfg_err`  out  1  one-cycle pulse: illegal `cfg_len` offered.
- `start`  in  1  begin run (honoured in ARMED only).
- `abort`  in  1  terminate run/arming, return to IDLE.
- `in_valid`  in  1  `in` carries a stream bit this cycle.
- `in`  in  1  serial stream bit.
- `match`  out  1  one-cycle pulse per detected match.
- `match_count`  out  CNT_W  matches in current/last run.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse, target reached.

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset: state IDLE, config regs 0, history 0, fill 0, `match_count`=0, `cfg_ready`=1, all pulses 0, `busy`=0.
- Handshake: transfer when `cfg_valid && cfg_ready`.
  - With `cfg_len` in 1..MAX_LEN, the block latches pattern, len, overlap and target, and goes to ARMED.
  - With `cfg_len`=0 or >MAX_LEN, nothing is latched, `cfg_err` pulses, and state is unchanged.
- IDLE: waits for config; `start` ignored.
- ARMED: new legal config overwrites the old one.
  - `start` → RUN: history cleared, fill=0, `match_count`=0.
  - `abort` → IDLE.
- RUN: `cfg_ready`=0, and `cfg_valid` is ignored.
  - On each `in_valid` cycle, next history = {history, `in`} (newest at LSB), and fill increments, saturating at MAX_LEN.
  - Match when (fill+1) ≥ len and the low `len` bits of the next history equal `cfg_pattern[len-1:0]`.
  - On match: `match` pulses and `match_count` increments, saturating at all-ones when target=0.
    - If `cfg_overlap`=0, fill resets to 0 (history bits are not reused).
    - If `cfg_overlap`=1, fill is kept.
  - If the incremented count equals a nonzero target → DONE.
  - No `in_valid`: no state change.
- DONE: `done`=1 for exactly this cycle → IDLE next edge. `match_count` holds until the next `start`.
- Priority in one cycle: `abort` > `start`/match. An aborted cycle produces no match, no count and no `done`. `abort` in RUN → IDLE with `match_count` held.
- `abort` in IDLE or DONE: ignored; DONE still returns to IDLE.
- `reset_n` low mid-run: immediate return to reset values; no `done`.

## Timing
- All outputs are registered.
- `match` is high in the cycle after the edge that samples the final pattern bit. `match_count` updates on the same edge.
- The target-reaching match asserts `match` and `done` in the same cycle; `busy` is 0 in that cycle.
- Accepting config at edge k gives ARMED and `cfg_ready`=1 from k. `start` sampled at edge k gives `busy`=1 from k.
- The first stream bit counted is the first `in_valid` sampled at or after edge k+1.
- Minimum turnaround: DONE→IDLE in 1 cycle. A new `start` needs config first: DONE always returns to IDLE, and config is retained but must be re-offered to re-arm.
- Throughput: one bit per cycle with `in_valid` held high. A match can occur every cycle when overlap=1 and len=1.

## Test plan
- Overlap: config 0110 (`cfg_pattern`=4'b0110, len 4, overlap 1, target 0); stream 0,1,1,0,1,1,0 → `match` after bits 4 and 7, `match_count`=2.
- Non-overlap: same pattern with overlap 0, same stream → single `match` after bit 4, `match_count`=1.
- Target and done: pattern 1 (len 1), target 3; stream 1,0,1,1 with `in_valid` gaps → `match` on bits 1,3,4, `done` with the third match; next cycle IDLE, `match_count`=3 held.
- Illegal config: `cfg_len`=0, then `cfg_len`=MAX_LEN+1 → `cfg_err` pulses each time, state stays IDLE, `start` ignored.
- Abort priority: in RUN, assert `abort` on the cycle whose bit would complete a match → no `match`, count unchanged, IDLE next cycle, `done`=0.
- Async reset mid-run: drop `reset_n` between edges with fill=3 → all outputs at reset values immediately, `cfg_ready`=1.
